// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: turns 10-bit SPI command words into single-beat memory
// accesses. Commands ([9:8] of rx_data):
//   00 load write address, 01 write payload, 10 load read address, 11 read.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_valid, rx_data        command strobe and word from the SPI slave
//   tx_data, tx_valid        read data and its one-cycle qualifier
//   mem_addr, mem_wdata      memory address and write data
//   mem_we, mem_re           request strobes, held until mem_ack or timeout
//   mem_ack, mem_rdata       memory completion and read data
//   busy                     FSM is not IDLE
//   err_overrun, err_timeout sticky error flags, cleared only by reset
// Build option: define ADDR_AUTOINC_EN to post-increment the write/read
// address after every acknowledged access.
module spi_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [9:0]            rx_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  err_overrun,
  output logic                  err_timeout
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WDATA = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CNT_W-1:0]      wait_cnt;
  // High for the first IDLE cycle after a transaction; a command arriving
  // then is dropped so the SPI side sees a clean turnaround.
  logic                  just_idle;

  logic [1:0]            cmd;
  logic [7:0]            payload;

  assign cmd     = rx_data[9:8];
  assign payload = rx_data[7:0];

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_addr     <= '0;
      rd_addr     <= '0;
      wait_cnt    <= '0;
      just_idle   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_valid  <= 1'b0;
      just_idle <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && !just_idle) begin
            case (cmd)
              CMD_WADDR: wr_addr <= payload[ADDR_WIDTH-1:0];
              CMD_RADDR: rd_addr <= payload[ADDR_WIDTH-1:0];
              CMD_WDATA: begin
                mem_addr  <= wr_addr;
                mem_wdata <= payload;
                mem_we    <= 1'b1;
                wait_cnt  <= '0;
                busy      <= 1'b1;
                state     <= WRITE;
              end
              CMD_READ: begin
                mem_addr <= rd_addr;
                mem_re   <= 1'b1;
                wait_cnt <= '0;
                busy     <= 1'b1;
                state    <= READ;
              end
              default: ;
            endcase
          end
        end

        WRITE: begin
          if (rx_valid) err_overrun <= 1'b1;
          if (mem_ack) begin
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            just_idle <= 1'b1;
            state     <= IDLE;
`ifdef ADDR_AUTOINC_EN
            wr_addr   <= wr_addr + ADDR_WIDTH'(1);
`endif
          end else if (wait_cnt == CNT_LAST) begin
            mem_we      <= 1'b0;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            just_idle   <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        READ: begin
          if (rx_valid) err_overrun <= 1'b1;
          if (mem_ack) begin
            tx_data <= mem_rdata;
            mem_re  <= 1'b0;
            state   <= RESP;
`ifdef ADDR_AUTOINC_EN
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
`endif
          end else if (wait_cnt == CNT_LAST) begin
            mem_re      <= 1'b0;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            just_idle   <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          // tx_valid becomes visible in the first IDLE cycle.
          if (rx_valid) err_overrun <= 1'b1;
          tx_valid  <= 1'b1;
          busy      <= 1'b0;
          just_idle <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
